data_gen_fifo_mc: RTL
=====================

Name: data_gen_fifo_mc

Overview:
Parametrised successor of the FIFO-side data generator. It writes `times` passes of `size` words each into a downstream FIFO, honouring fifo_full backpressure. Each word packs LANES sub-words and is built by a selectable pattern mode: increment, constant, LFSR or pass-index. It adds a per-pass last flag and a written-word counter. It sits between the ap_ctrl host handshake and the write port of a standard FIFO feeding AXI-MM/stream test paths.

Parameters:
LANE_W, 8, bits per lane
LANES, 4, lanes per FIFO word; WIDTH = LANE_W*LANES
LFSR_TAPS, 32'h80200003, Galois tap mask for mode LFSR; width WIDTH, truncated or extended to WIDTH

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst  in  1  asynchronous active-high reset
size  in  32  words per pass, latched at start
times  in  32  number of passes, latched at start
mode  in  2  pattern: 0 INC, 1 CONST, 2 LFSR, 3 PASS; latched at start
seed  in  LANE_W  pattern seed, latched at start
fifo_wr_en  out  1  write strobe
fifo_wr_data  out  WIDTH  write data; lane k = bits [k*LANE_W +: LANE_W]
fifo_wr_last  out  1  qualifies the last word of each pass
fifo_full  in  1  FIFO full; no write while high
ap_start  in  1  start request
ap_done  out  1  one-cycle completion pulse
ap_idle  out  1  high in IDLE
ap_ready  out  1  start accepted, same cycle
words_written  out  32  words written since last start, wraps mod 2^32

Behaviour:
- Reset (async, ap_rst=1): state IDLE, counters 0. Outputs fifo_wr_en=0, fifo_wr_data=0, fifo_wr_last=0, ap_done=0, ap_ready=0, ap_idle=1, words_written=0.
- Reset mid-run: writes stop the same cycle. The block returns to IDLE with no ap_done.
- States: IDLE, RUN, DONE.
- IDLE:
  - ap_idle=1.
  - ap_start=1: ap_ready=1 combinationally that cycle. Latch size/times/mode/seed. Clear words_written, word_idx and pass_idx. Load the pattern.
  - Next state: DONE if size==0 or times==0, else RUN.
- RUN:
  - fifo_wr_en = !fifo_full, combinational from fifo_full.
  - fifo_wr_data and fifo_wr_last are valid every RUN cycle and hold while fifo_full=1.
  - On a write: word_idx increments and words_written increments.
  - fifo_wr_last = (word_idx==size-1).
  - On a write with last=1: word_idx returns to 0 and pass_idx increments; the pattern reloads per mode.
  - Write of the last word of pass times-1 -> DONE.
  - First write can occur in the first RUN cycle. Peak throughput is 1 word/clk.
- DONE: ap_done=1 for exactly one cycle, then IDLE.
- ap_start outside IDLE is ignored. Latched config is unaffected by input changes during RUN.
- Pattern rules (arithmetic mod 2^LANE_W, except LFSR):
  - INC: lane k of word i in a pass = seed + i*LANES + k. The sequence restarts at seed each pass.
  - CONST: every lane = seed.
  - LFSR: WIDTH-bit Galois register.
    - Init = seed replicated across lanes; an all-zero init is forced to 1.
    - The register advances one step per write and is not reset between passes.
  - PASS: every lane = pass_idx[LANE_W-1:0].
- Counters are 32 bit. size=times=2^32-1 must work (no overflow in the compares).

Decomposition:
- Shared package data_gen_pkg:
  - state enum (IDLE/RUN/DONE)
  - mode constants MODE_INC/MODE_CONST/MODE_LFSR/MODE_PASS
  - default LFSR_TAPS
- Sub-module data_gen_pattern, parametrised LANE_W/LANES/LFSR_TAPS.
  - Inputs: load, advance, pass_restart, mode, seed, pass_idx.
  - Output: registered word.
- The top holds the FSM, counters and handshake.

Test Plan:
- LANE_W=8, LANES=4, mode INC, seed=0x10, size=3, times=2, fifo_full=0 -> writes 0x13121110, 0x17161514, 0x1B1A1918, then repeated. last=1 on words 3 and 6. ap_done 1 cycle after the 6th write. words_written=6.
- Same config, fifo_full high for 5 cycles after the 2nd write -> no wr_en during stall, data held at 0x1B1A1918. Total 6 writes, same values.
- mode CONST seed=0xAA, size=4, times=1 -> four writes of 0xAAAAAAAA, last on the 4th. ap_start pulsed during RUN is ignored: ap_ready stays 0.
- size=0 times=5, and size=5 times=0 -> ap_ready on start, ap_done next cycle. No writes; words_written=0.
- mode LFSR seed=0x00 -> init word 0x00000001. Subsequent words match a reference Galois model with taps 0x80200003, continuous across passes.
- ap_rst asserted after 2 writes of a size=8 run -> wr_en=0 immediately, ap_idle=1, words_written=0, no ap_done. A new start then runs cleanly from seed.

Source files
------------

// File: rtl/data_gen_pkg.sv
// Shared definitions for the FIFO-side multi-lane data generator:
// FSM state encoding, pattern mode codes and the default LFSR tap mask.
package data_gen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_INC   = 2'd0;
    localparam mode_t MODE_CONST = 2'd1;
    localparam mode_t MODE_LFSR  = 2'd2;
    localparam mode_t MODE_PASS  = 2'd3;

    localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h80200003;

endpackage

// File: rtl/data_gen_pattern.sv
// Pattern word generator: holds the next FIFO word and updates it on
// start (load), on every accepted write (advance) and at pass boundaries.
module data_gen_pattern
    import data_gen_pkg::*;
#(
    parameter int          LANE_W    = 8,
    parameter int          LANES     = 4,
    parameter logic [31:0] LFSR_TAPS = DEFAULT_LFSR_TAPS,
    localparam int         WIDTH     = LANE_W * LANES
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              load,
    input  logic              advance,
    input  logic              pass_restart,
    input  logic [1:0]        mode,
    input  logic [LANE_W-1:0] seed,
    input  logic [LANE_W-1:0] pass_idx,
    output logic [WIDTH-1:0]  word
);

    // Tap mask sized to the word: truncated or zero-extended
    localparam logic [WIDTH-1:0] TAPS_W = WIDTH'(LFSR_TAPS);

    function automatic logic [WIDTH-1:0] replicate(input logic [LANE_W-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            r[k*LANE_W +: LANE_W] = v;
        end
        return r;
    endfunction

    // First word of an INC pass: lane k = seed + k
    function automatic logic [WIDTH-1:0] inc_base(input logic [LANE_W-1:0] s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            r[k*LANE_W +: LANE_W] = s + LANE_W'(k);
        end
        return r;
    endfunction

    // Next INC word: every lane moves forward by LANES
    function automatic logic [WIDTH-1:0] inc_step(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            r[k*LANE_W +: LANE_W] = w[k*LANE_W +: LANE_W] + LANE_W'(LANES);
        end
        return r;
    endfunction

    // Right-shifting Galois step; feedback bit XORs the tap mask in
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] w);
        return (w >> 1) ^ (w[0] ? TAPS_W : '0);
    endfunction

    // An all-zero register would lock up, so it is forced to 1
    function automatic logic [WIDTH-1:0] lfsr_init(input logic [LANE_W-1:0] s);
        logic [WIDTH-1:0] r;
        r = replicate(s);
        if (r == '0) begin
            r = WIDTH'(1);
        end
        return r;
    endfunction

    // Pattern register: load at start, then update on each write
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            word <= '0;
        end else if (load) begin
            case (mode)
                MODE_INC:   word <= inc_base(seed);
                MODE_CONST: word <= replicate(seed);
                MODE_LFSR:  word <= lfsr_init(seed);
                default:    word <= '0;
            endcase
        end else if (advance) begin
            case (mode)
                MODE_INC:   word <= pass_restart ? inc_base(seed) : inc_step(word);
                MODE_CONST: word <= replicate(seed);
                MODE_LFSR:  word <= lfsr_step(word);
                default:    word <= pass_restart ? replicate(pass_idx) : word;
            endcase
        end
    end

endmodule

// File: rtl/data_gen_fifo_mc.sv
// Multi-lane FIFO data generator: writes `times` passes of `size` words
// into a FIFO write port under ap_ctrl handshake, respecting fifo_full.
module data_gen_fifo_mc
    import data_gen_pkg::*;
#(
    parameter int          LANE_W    = 8,
    parameter int          LANES     = 4,
    parameter logic [31:0] LFSR_TAPS = DEFAULT_LFSR_TAPS,
    localparam int         WIDTH     = LANE_W * LANES
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [31:0]       size,
    input  logic [31:0]       times,
    input  logic [1:0]        mode,
    input  logic [LANE_W-1:0] seed,
    output logic              fifo_wr_en,
    output logic [WIDTH-1:0]  fifo_wr_data,
    output logic              fifo_wr_last,
    input  logic              fifo_full,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [31:0]       words_written
);

    state_t            state;
    logic [31:0]       size_q;
    logic [31:0]       times_q;
    logic [1:0]        mode_q;
    logic [LANE_W-1:0] seed_q;
    logic [31:0]       word_idx;
    logic [31:0]       pass_idx;

    logic              start_acc;
    logic              wr;
    logic              last_word;
    logic              last_pass;
    logic [1:0]        cfg_mode;
    logic [LANE_W-1:0] cfg_seed;
    logic [31:0]       pass_idx_nxt;
    logic [WIDTH-1:0]  pat_word;

    assign start_acc = (state == ST_IDLE) && ap_start;
    assign wr        = (state == ST_RUN) && !fifo_full;

    // size_q/times_q are non-zero whenever RUN is entered, so the -1 cannot wrap
    assign last_word = (word_idx == size_q - 32'd1);
    assign last_pass = (pass_idx == times_q - 32'd1);

    // The pattern loads in the same cycle the config is latched, so it sees the raw inputs then
    assign cfg_mode     = start_acc ? mode : mode_q;
    assign cfg_seed     = start_acc ? seed : seed_q;
    assign pass_idx_nxt = pass_idx + 32'd1;

    assign ap_ready      = start_acc;
    assign ap_idle       = (state == ST_IDLE);
    assign ap_done       = (state == ST_DONE);
    assign fifo_wr_en    = wr;
    assign fifo_wr_data  = (state == ST_RUN) ? pat_word : '0;
    assign fifo_wr_last  = (state == ST_RUN) && last_word;

    data_gen_pattern #(
        .LANE_W    (LANE_W),
        .LANES     (LANES),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_pattern (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .load         (start_acc),
        .advance      (wr),
        .pass_restart (wr && last_word),
        .mode         (cfg_mode),
        .seed         (cfg_seed),
        .pass_idx     (LANE_W'(pass_idx_nxt)),
        .word         (pat_word)
    );

    // Control FSM, latched configuration and word/pass/write counters
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state         <= ST_IDLE;
            size_q        <= '0;
            times_q       <= '0;
            mode_q        <= '0;
            seed_q        <= '0;
            word_idx      <= '0;
            pass_idx      <= '0;
            words_written <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        size_q        <= size;
                        times_q       <= times;
                        mode_q        <= mode;
                        seed_q        <= seed;
                        word_idx      <= '0;
                        pass_idx      <= '0;
                        words_written <= '0;
                        state         <= (size == 32'd0 || times == 32'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wr) begin
                        words_written <= words_written + 32'd1;
                        if (last_word) begin
                            word_idx <= '0;
                            pass_idx <= pass_idx_nxt;
                            if (last_pass) begin
                                state <= ST_DONE;
                            end
                        end else begin
                            word_idx <= word_idx + 32'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
